wb_dma_req_ctrl: RTL and testbench
==================================

# wb_dma_req_ctrl

Peripheral-side DMA request controller that drives the hardware handshake inputs of the Wishbone DMA engine. Per channel, it accumulates transfer credits from a data source (FIFO watermark pulses) and converts them into the engine's level `dma_req` / pulse `dma_ack` protocol. It also generates `dma_nd` (new descriptor at frame end) and `dma_rest` (restart on abort). It sits directly upstream of the DMA wrapper: its outputs connect 1:1 to `dma_req_i`, `dma_nd_i` and `dma_rest_i`, and it consumes `dma_ack_o`.

## Interface
- `ch_count`, default 31: number of channels; must match the DMA instance.
- `cnt_w`, default 8: credit counter width per channel; counter max is 2^cnt_w−1.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `src_rdy_i` in ch_count: one-cycle pulse per bit meaning one burst of data is ready (+1 credit).
- `src_eof_i` in ch_count: qualifies `src_rdy_i`; marks that burst as the end of a frame.
- `abort_i` in ch_count: one-cycle pulse that flushes the channel.
- `ovf_clr_i` in ch_count: one-cycle pulse that clears the sticky overflow bit.
- `dma_ack_i` in ch_count: from DMA `dma_ack_o`; one-cycle pulse per serviced request.
- `dma_req_o` out ch_count: registered request level, to DMA `dma_req_i`.
- `dma_nd_o` out ch_count: registered one-cycle pulse, to DMA `dma_nd_i`.
- `dma_rest_o` out ch_count: registered one-cycle pulse, to DMA `dma_rest_i`.
- `ovf_o` out ch_count: sticky per-channel overflow flag.
- `irq_o` out 1: registered OR of `ovf_o`.

## Operation
Each channel has the following state:
- Credit counter `cnt`.
- EOF-pending flag `eofp`.
- Overflow flag `ovf`.
- Three-state FSM:
  - IDLE: `req` = 0. Moves to REQ when the next `cnt` is nonzero.
  - REQ: `req` = 1. On `dma_ack_i` moves to HOLD.
  - HOLD: `req` = 0 for exactly one cycle, the re-arm gap. The engine samples the level request, so this gap prevents a double service. Next state is REQ if `cnt` ≠ 0, otherwise IDLE.

Counter update for one cycle, net of all events:
- `cnt_next = cnt + rdy − ack_in_REQ`.
- `rdy` and a valid ack in the same cycle leave `cnt` unchanged.
- At max, `rdy` without ack saturates `cnt` and sets `ovf`.
- `dma_ack_i` outside REQ is ignored and does not decrement.

Frame end:
- `src_rdy_i & src_eof_i` sets `eofp`.
- An ack that drives `cnt` to 0 while `eofp` = 1 pulses `dma_nd_o` for one cycle and clears `eofp`.
- If `eofp` is set and a new `rdy` arrives in the ack cycle, `cnt` stays nonzero and there is no `nd`.

Abort (highest priority):
- `abort_i` forces `cnt` = 0, clears `eofp`, moves the FSM to IDLE and pulses `dma_rest_o` for one cycle.
- `src_rdy_i` and `dma_ack_i` in the same cycle are discarded.
- `ovf` is unaffected by abort.

Overflow clear:
- `ovf_clr_i` clears `ovf`.
- If it coincides with a new overflow, set wins.

Channels are fully independent; there is no arbitration, which is done inside the DMA engine.

## Timing
- Reset (`rst_n` low at an edge): `cnt` = 0, `eofp` = 0, `ovf` = 0, FSM = IDLE. All outputs (`dma_req_o`, `dma_nd_o`, `dma_rest_o`, `ovf_o`, `irq_o`) are 0 from the following cycle.
- Reset mid-request drops `req` without waiting for an ack. Any late ack is ignored.
- `src_rdy_i` in cycle N: `dma_req_o` is high in N+1 (1-cycle latency) when starting from IDLE.
- `dma_ack_i` in cycle M:
  - `dma_req_o` is low in M+1.
  - `dma_req_o` is high again in M+2 if credits remain.
  - `dma_nd_o` is high in M+1 only.
- `abort_i` in cycle A: `dma_rest_o` is high in A+1, `dma_req_o` is low in A+1.
- `irq_o` lags `ovf_o` by one cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `wb_dma_req_pkg`:
  - `typedef enum logic [1:0] {IDLE, REQ, HOLD} req_state_e`.
  - Constant `CNT_W_DEF = 8`.
- Sub-module `wb_dma_req_ch`: one channel (FSM, counter, flags). It is instantiated `ch_count` times in a generate loop.
- The top level instantiates the channels and registers the OR-reduction for `irq_o`.

## Test plan
- **Single credit.** Reset, then a ch0 `src_rdy_i` pulse at cycle 10. Required: `dma_req_o[0]` is 1 in cycle 11. Ack at cycle 14: `req` is 0 in cycles 15 onward, `cnt` = 0, and `dma_nd_o` is not pulsed.
- **Three credits, frame end.** Three `rdy` pulses on ch3, the last with `src_eof_i`, then acks spaced 3 cycles apart. Required: `req` goes low for exactly 1 cycle after each ack. `dma_nd_o[3]` pulses once, 1 cycle after the third ack. Final `cnt` = 0.
- **Simultaneous rdy and ack.** `cnt` = 1 and `rdy` coincides with an ack. Required: `cnt` stays 1, `req` shows the HOLD gap (0 for one cycle) then returns to 1, and there is no `nd`.
- **Saturation.** `cnt_w` = 2 with five `rdy` pulses on ch1. Required: `cnt` saturates at 3, `ovf_o[1]` = 1, and `irq_o` = 1 one cycle later. `ovf_clr_i` then clears both.
- **Abort.** Abort during REQ with `cnt` = 2 and `eofp` = 1. Required: `dma_rest_o` pulses once, `req` is 0 next cycle, and `cnt` = 0. A subsequent ack causes no change and no `nd`.
- **Reset mid-operation.** Drive `rst_n` low while ch0 is in REQ. Required: all outputs are 0 next cycle, and there is no stale `req` after reset is released.

Source files
------------

// File: rtl/wb_dma_req_pkg.sv
// Shared types and defaults for the DMA request controller slice.
package wb_dma_req_pkg;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} req_state_e;

  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/wb_dma_req_ch.sv
// One DMA request channel: credit counter, EOF/overflow flags and the
// level-request FSM with a one-cycle re-arm gap after every ack.
module wb_dma_req_ch
  import wb_dma_req_pkg::*;
#(
  parameter int cnt_w = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src_rdy_i,
  input  logic src_eof_i,
  input  logic abort_i,
  input  logic ovf_clr_i,
  input  logic dma_ack_i,
  output logic dma_req_o,
  output logic dma_nd_o,
  output logic dma_rest_o,
  output logic ovf_o
);

  localparam logic [cnt_w-1:0] CNT_MAX = '1;

  req_state_e       state;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] cnt_next;
  logic             eofp;
  logic             ack_v;
  logic             ovf_set;
  logic             nd_fire;

  // Acks only count while the request is being presented.
  always_comb begin
    ack_v    = dma_ack_i && (state == REQ);
    cnt_next = cnt;
    ovf_set  = 1'b0;
    if (src_rdy_i && !ack_v) begin
      if (cnt == CNT_MAX) ovf_set = 1'b1;
      else                cnt_next = cnt + 1'b1;
    end else if (ack_v && !src_rdy_i) begin
      cnt_next = cnt - 1'b1;
    end
    nd_fire = ack_v && eofp && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      eofp       <= 1'b0;
      ovf_o      <= 1'b0;
      dma_req_o  <= 1'b0;
      dma_nd_o   <= 1'b0;
      dma_rest_o <= 1'b0;
    end else begin
      // Abort discards rdy, so it can never raise a new overflow.
      ovf_o <= (ovf_set && !abort_i) || (ovf_o && !ovf_clr_i);
      if (abort_i) begin
        state      <= IDLE;
        cnt        <= '0;
        eofp       <= 1'b0;
        dma_req_o  <= 1'b0;
        dma_nd_o   <= 1'b0;
        dma_rest_o <= 1'b1;
      end else begin
        cnt        <= cnt_next;
        eofp       <= (eofp && !nd_fire) || (src_rdy_i && src_eof_i);
        dma_nd_o   <= nd_fire;
        dma_rest_o <= 1'b0;
        case (state)
          IDLE: begin
            if (cnt_next != '0) begin
              state     <= REQ;
              dma_req_o <= 1'b1;
            end
          end
          REQ: begin
            if (ack_v) begin
              state     <= HOLD;
              dma_req_o <= 1'b0;
            end
          end
          HOLD: begin
            if (cnt_next != '0) begin
              state     <= REQ;
              dma_req_o <= 1'b1;
            end else begin
              state     <= IDLE;
              dma_req_o <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            dma_req_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/wb_dma_req_ctrl.sv
// Peripheral-side DMA request controller: independent per-channel request
// engines plus a registered overflow interrupt.
module wb_dma_req_ctrl
  import wb_dma_req_pkg::*;
#(
  parameter int ch_count = 31,
  parameter int cnt_w    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ch_count-1:0] src_rdy_i,
  input  logic [ch_count-1:0] src_eof_i,
  input  logic [ch_count-1:0] abort_i,
  input  logic [ch_count-1:0] ovf_clr_i,
  input  logic [ch_count-1:0] dma_ack_i,
  output logic [ch_count-1:0] dma_req_o,
  output logic [ch_count-1:0] dma_nd_o,
  output logic [ch_count-1:0] dma_rest_o,
  output logic [ch_count-1:0] ovf_o,
  output logic                irq_o
);

  for (genvar c = 0; c < ch_count; c++) begin : g_ch
    wb_dma_req_ch #(.cnt_w(cnt_w)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_rdy_i  (src_rdy_i[c]),
      .src_eof_i  (src_eof_i[c]),
      .abort_i    (abort_i[c]),
      .ovf_clr_i  (ovf_clr_i[c]),
      .dma_ack_i  (dma_ack_i[c]),
      .dma_req_o  (dma_req_o[c]),
      .dma_nd_o   (dma_nd_o[c]),
      .dma_rest_o (dma_rest_o[c]),
      .ovf_o      (ovf_o[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) irq_o <= 1'b0;
    else        irq_o <= |ovf_o;
  end

endmodule

// File: tb/tb_wb_dma_req_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a credit-level model.
module tb_wb_dma_req_ctrl;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] src_rdy_i = '0;
  logic [N-1:0] src_eof_i = '0;
  logic [N-1:0] abort_i = '0;
  logic [N-1:0] ovf_clr_i = '0;
  logic [N-1:0] dma_ack_i = '0;
  logic [N-1:0] dma_req_o;
  logic [N-1:0] dma_nd_o;
  logic [N-1:0] dma_rest_o;
  logic [N-1:0] ovf_o;
  logic         irq_o;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model state: credits, pending frame end, and expected outputs.
  int           m_cnt [N];
  logic [N-1:0] m_eofp = '0;
  logic [N-1:0] exp_req = '0;
  logic [N-1:0] exp_nd = '0;
  logic [N-1:0] exp_rest = '0;
  logic [N-1:0] exp_ovf = '0;
  logic         exp_irq = 1'b0;

  wb_dma_req_ctrl #(.ch_count(N), .cnt_w(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_rdy_i  (src_rdy_i),
    .src_eof_i  (src_eof_i),
    .abort_i    (abort_i),
    .ovf_clr_i  (ovf_clr_i),
    .dma_ack_i  (dma_ack_i),
    .dma_req_o  (dma_req_o),
    .dma_nd_o   (dma_nd_o),
    .dma_rest_o (dma_rest_o),
    .ovf_o      (ovf_o),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Request is high whenever credits remain, except the cycle after an ack.
  always @(posedge clk) begin
    logic [N-1:0] req_n, nd_n, rest_n, ovf_n, eofp_n;
    int nc;
    bit av;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
      m_eofp = '0; exp_req = '0; exp_nd = '0; exp_rest = '0;
      exp_ovf = '0; exp_irq = 1'b0;
    end else begin
      for (int c = 0; c < N; c++) begin
        av = dma_ack_i[c] && exp_req[c];
        if (abort_i[c]) begin
          nc = 0;
          req_n[c] = 1'b0; nd_n[c] = 1'b0; rest_n[c] = 1'b1; eofp_n[c] = 1'b0;
          ovf_n[c] = exp_ovf[c] && !ovf_clr_i[c];
        end else begin
          nc = m_cnt[c] + int'(src_rdy_i[c]) - int'(av);
          ovf_n[c] = exp_ovf[c] && !ovf_clr_i[c];
          if (nc > MAX) begin
            nc = MAX;
            ovf_n[c] = 1'b1;
          end
          nd_n[c]   = av && (nc == 0) && m_eofp[c];
          eofp_n[c] = (m_eofp[c] && !nd_n[c]) || (src_rdy_i[c] && src_eof_i[c]);
          req_n[c]  = !av && (nc != 0);
          rest_n[c] = 1'b0;
        end
        m_cnt[c] = nc;
      end
      exp_irq  = |exp_ovf;
      m_eofp   = eofp_n;
      exp_req  = req_n;
      exp_nd   = nd_n;
      exp_rest = rest_n;
      exp_ovf  = ovf_n;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_req",  32'(dma_req_o),  32'(exp_req));
      checkOutput("model_nd",   32'(dma_nd_o),   32'(exp_nd));
      checkOutput("model_rest", 32'(dma_rest_o), 32'(exp_rest));
      checkOutput("model_ovf",  32'(ovf_o),      32'(exp_ovf));
      checkOutput("model_irq",  32'(irq_o),      32'(exp_irq));
    end
  end

  task automatic applyStimulus(input logic rst_v, input logic [N-1:0] rdy, input logic [N-1:0] eof,
                               input logic [N-1:0] abrt, input logic [N-1:0] clr, input logic [N-1:0] ack);
    rst_n = rst_v; src_rdy_i = rdy; src_eof_i = eof;
    abort_i = abrt; ovf_clr_i = clr; dma_ack_i = ack;
    @(posedge clk);
    #1;
    src_rdy_i = '0; src_eof_i = '0; abort_i = '0; ovf_clr_i = '0; dma_ack_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [N-1:0] rdy, eof, abrt, clr, ack;

    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    check_en = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    checkOutput("reset_req", 32'(dma_req_o), 32'h0);
    checkOutput("reset_ovf_irq", {27'd0, ovf_o, irq_o}, 32'h0);

    // Single credit on ch0.
    idle(3);
    applyStimulus(1'b1, 4'b0001, '0, '0, '0, '0);
    checkOutput("single_req_up", 32'(dma_req_o[0]), 32'h1);
    idle(2);
    applyStimulus(1'b1, '0, '0, '0, '0, 4'b0001);
    checkOutput("single_req_down", 32'(dma_req_o[0]), 32'h0);
    checkOutput("single_no_nd", 32'(dma_nd_o[0]), 32'h0);
    idle(1);
    checkOutput("single_stays_low", 32'(dma_req_o[0]), 32'h0);

    // Three credits on ch3, last one ends a frame.
    applyStimulus(1'b1, 4'b1000, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b1000, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b1000, 4'b1000, '0, '0, '0);
    for (int a = 0; a < 3; a++) begin
      applyStimulus(1'b1, '0, '0, '0, '0, 4'b1000);
      checkOutput("frame_gap", 32'(dma_req_o[3]), 32'h0);
      checkOutput("frame_nd", 32'(dma_nd_o[3]), (a == 2) ? 32'h1 : 32'h0);
      idle(1);
      checkOutput("frame_rearm", 32'(dma_req_o[3]), (a == 2) ? 32'h0 : 32'h1);
      checkOutput("frame_nd_once", 32'(dma_nd_o[3]), 32'h0);
      idle(1);
    end

    // rdy coinciding with an ack keeps one credit.
    applyStimulus(1'b1, 4'b0100, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b0100, '0, '0, '0, 4'b0100);
    checkOutput("simul_gap", 32'(dma_req_o[2]), 32'h0);
    idle(1);
    checkOutput("simul_rearm", 32'(dma_req_o[2]), 32'h1);
    applyStimulus(1'b1, '0, '0, '0, '0, 4'b0100);
    idle(1);
    checkOutput("simul_drained", 32'(dma_req_o[2]), 32'h0);

    // Saturation on ch1.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0010, '0, '0, '0, '0);
    checkOutput("sat_ovf", 32'(ovf_o[1]), 32'h1);
    idle(1);
    checkOutput("sat_irq", 32'(irq_o), 32'h1);
    applyStimulus(1'b1, '0, '0, '0, 4'b0010, '0);
    checkOutput("sat_ovf_clr", 32'(ovf_o[1]), 32'h0);
    idle(1);
    checkOutput("sat_irq_clr", 32'(irq_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, '0, '0, '0, '0, 4'b0010);
      idle(1);
    end
    checkOutput("sat_three_served", 32'(dma_req_o[1]), 32'h0);

    // Abort on ch2 with two credits and a pending frame end.
    applyStimulus(1'b1, 4'b0100, '0, '0, '0, '0);
    applyStimulus(1'b1, 4'b0100, 4'b0100, '0, '0, '0);
    applyStimulus(1'b1, '0, '0, 4'b0100, '0, '0);
    checkOutput("abort_rest", 32'(dma_rest_o[2]), 32'h1);
    checkOutput("abort_req", 32'(dma_req_o[2]), 32'h0);
    applyStimulus(1'b1, '0, '0, '0, '0, 4'b0100);
    checkOutput("abort_ack_nd", 32'(dma_nd_o[2]), 32'h0);
    checkOutput("abort_rest_once", 32'(dma_rest_o[2]), 32'h0);
    checkOutput("abort_req_stays", 32'(dma_req_o[2]), 32'h0);

    // Reset while ch0 requests.
    applyStimulus(1'b1, 4'b0001, '0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, '0, '0);
    checkOutput("rst_mid_req", 32'(dma_req_o), 32'h0);
    idle(3);
    checkOutput("rst_no_stale", 32'(dma_req_o[0]), 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        rdy[c]  = ($urandom_range(0, 3) == 0);
        eof[c]  = ($urandom_range(0, 1) == 0);
        abrt[c] = ($urandom_range(0, 39) == 0);
        clr[c]  = ($urandom_range(0, 19) == 0);
        ack[c]  = exp_req[c] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      end
      applyStimulus(($urandom_range(0, 499) != 0), rdy, eof, abrt, clr, ack);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
